// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command-driven sequencer around a 4-bit maximal-length LFSR
// (x^4+x^3+1). It accepts SEED / STEP / SEEK / NOP commands over a valid/ready
// port and reports the live state, step count and completion status.
// Optional feature macro: LFSR_SEQ_CTRL_LOCKUP_DET_EN enables all-zero lockup
// detection. With the macro defined, zero seeds are rejected and runs from
// state 0 are refused, both raising err. With it undefined, err is tied low.
module lfsr_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_arg,
  input  logic             i_abort,
  output logic [3:0]       o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_match,
  output logic [CNT_W-1:0] o_steps,
  output logic             o_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_SEEK = 2'd2;

  localparam logic [1:0] OP_SEED = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_SEEK = 2'd2;

  logic [1:0]       r_fsm;
  logic [3:0]       r_state;
  logic [3:0]       r_target;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_steps;
  logic             r_done;
  logic             r_match;

  logic             w_accept;
  logic [3:0]       w_next;
  logic             w_seed_reject;
  logic             w_run_reject;

  assign w_accept = i_cmd_valid && (r_fsm == ST_IDLE);
  assign w_next   = {r_state[2:0], r_state[3] ^ r_state[2]};

`ifdef LFSR_SEQ_CTRL_LOCKUP_DET_EN
  logic r_err;

  assign w_seed_reject = (i_cmd_arg[3:0] == 4'd0);
  assign w_run_reject  = (r_state == 4'd0);

  // Lockup error: cleared by every accept, set when the accepted command is refused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= ((i_cmd_op == OP_SEED) && w_seed_reject) ||
               (((i_cmd_op == OP_STEP) || (i_cmd_op == OP_SEEK)) && w_run_reject);
    end
  end

  assign o_err = r_err;
`else
  assign w_seed_reject = 1'b0;
  assign w_run_reject  = 1'b0;
  assign o_err         = 1'b0;
`endif

  // Command FSM: owns the LFSR, the step counter, and the done/match flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_state     <= 4'b0001;
      r_target    <= 4'd0;
      r_remaining <= '0;
      r_steps     <= '0;
      r_done      <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_match <= 1'b0;
            r_steps <= '0;
            case (i_cmd_op)
              OP_SEED: begin
                if (!w_seed_reject) r_state <= i_cmd_arg[3:0];
                r_done <= 1'b1;
              end
              OP_STEP: begin
                if (w_run_reject || (i_cmd_arg == '0)) begin
                  r_done <= 1'b1;
                end else begin
                  r_fsm       <= ST_STEP;
                  r_remaining <= i_cmd_arg;
                end
              end
              OP_SEEK: begin
                if (w_run_reject) begin
                  r_done <= 1'b1;
                end else begin
                  r_fsm    <= ST_SEEK;
                  r_target <= i_cmd_arg[3:0];
                end
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        ST_STEP: begin
          if (r_remaining == CNT_W'(1)) begin
            r_state <= w_next;
            r_steps <= r_steps + CNT_W'(1);
            r_done  <= 1'b1;
            r_fsm   <= ST_IDLE;
          end else if (i_abort) begin
            r_done <= 1'b1;
            r_fsm  <= ST_IDLE;
          end else begin
            r_state     <= w_next;
            r_steps     <= r_steps + CNT_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        ST_SEEK: begin
          if (r_state == r_target) begin
            r_match <= 1'b1;
            r_done  <= 1'b1;
            r_fsm   <= ST_IDLE;
          end else if (i_abort) begin
            r_done <= 1'b1;
            r_fsm  <= ST_IDLE;
          end else begin
            r_state <= w_next;
            r_steps <= r_steps + CNT_W'(1);
            if (r_steps == CNT_W'(14)) begin
              r_done <= 1'b1;
              r_fsm  <= ST_IDLE;
            end
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_fsm == ST_IDLE);
  assign o_busy      = (r_fsm != ST_IDLE);
  assign o_state     = r_state;
  assign o_done      = r_done;
  assign o_match     = r_match;
  assign o_steps     = r_steps;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: directed bench for lfsr_seq_ctrl with hand-computed
// expected values. LFSR order from 1: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8.
module tb_lfsr_seq_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_op;
  logic [CNT_W-1:0] i_cmd_arg;
  logic             i_abort;
  logic [3:0]       o_state;
  logic             o_busy;
  logic             o_done;
  logic             o_match;
  logic [CNT_W-1:0] o_steps;
  logic             o_err;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;
  int edges;
  int d0;

  lfsr_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_arg   (i_cmd_arg),
    .i_abort     (i_abort),
    .o_state     (o_state),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_match     (o_match),
    .o_steps     (o_steps),
    .o_err       (o_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Count done pulses mid-cycle so every one-cycle pulse is seen exactly once
  always @(negedge clk) if (o_done) doneCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one command at a negedge, hold it until accepted, return 1ns after the accept edge
  task automatic applyStimulus(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_arg   = arg;
    for (int i = 0; i < 50 && !o_cmd_ready; i++) @(negedge clk);
    if (!o_cmd_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  // Count edges from the accept edge until done is seen, bounded by budget
  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (!o_done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!o_done) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'd0;
    i_cmd_arg   = '0;
    i_abort     = 1'b0;
    #12;
    checkOutput("rstState", 32'(o_state), 32'd1);
    checkOutput("rstReady", 32'(o_cmd_ready), 32'd1);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstDone", 32'(o_done), 32'd0);
    checkOutput("rstMatch", 32'(o_match), 32'd0);
    checkOutput("rstSteps", 32'(o_steps), 32'd0);
    checkOutput("rstErr", 32'(o_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SEED 1 then STEP 3
    applyStimulus(2'd0, 8'd1);
    waitDone(4, edges);
    checkOutput("seedLatency", 32'(edges), 32'd0);
    checkOutput("seedState", 32'(o_state), 32'd1);
    applyStimulus(2'd1, 8'd3);
    checkOutput("stepBusy", 32'(o_busy), 32'd1);
    checkOutput("stepReady", 32'(o_cmd_ready), 32'd0);
    waitDone(10, edges);
    checkOutput("stepLatency", 32'(edges), 32'd3);
    checkOutput("stepState", 32'(o_state), 32'd9);
    checkOutput("stepSteps", 32'(o_steps), 32'd3);
    @(posedge clk); #1;
    checkOutput("donePulse", 32'(o_done), 32'd0);

    // STEP 0 completes on the accept edge
    applyStimulus(2'd1, 8'd0);
    waitDone(4, edges);
    checkOutput("step0Latency", 32'(edges), 32'd0);
    checkOutput("step0State", 32'(o_state), 32'd9);
    checkOutput("step0Steps", 32'(o_steps), 32'd0);
    checkOutput("step0Busy", 32'(o_busy), 32'd0);

    // SEED 1 then SEEK 8: last element of the period, 14 advances
    applyStimulus(2'd0, 8'd1);
    waitDone(4, edges);
    applyStimulus(2'd2, 8'd8);
    waitDone(20, edges);
    checkOutput("seek8Latency", 32'(edges), 32'd15);
    checkOutput("seek8Match", 32'(o_match), 32'd1);
    checkOutput("seek8Steps", 32'(o_steps), 32'd14);
    checkOutput("seek8State", 32'(o_state), 32'd8);
    @(posedge clk); #1;
    checkOutput("matchHeld", 32'(o_match), 32'd1);

    // SEED clears match; SEEK 1 from 1 matches with no advance
    applyStimulus(2'd0, 8'd1);
    checkOutput("matchCleared", 32'(o_match), 32'd0);
    applyStimulus(2'd2, 8'd1);
    waitDone(20, edges);
    checkOutput("seek1Latency", 32'(edges), 32'd1);
    checkOutput("seek1Match", 32'(o_match), 32'd1);
    checkOutput("seek1Steps", 32'(o_steps), 32'd0);

    // Reserved op: done, clears match, no state change
    applyStimulus(2'd3, 8'd7);
    waitDone(4, edges);
    checkOutput("nopLatency", 32'(edges), 32'd0);
    checkOutput("nopMatch", 32'(o_match), 32'd0);
    checkOutput("nopState", 32'(o_state), 32'd1);

    // STEP 200 aborted after 5 advances: 1->2->4->9->3->6
    applyStimulus(2'd0, 8'd1);
    applyStimulus(2'd1, 8'd200);
    d0 = doneCount;
    repeat (5) begin @(posedge clk); #1; end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    checkOutput("abortDone", 32'(o_done), 32'd1);
    checkOutput("abortState", 32'(o_state), 32'd6);
    checkOutput("abortSteps", 32'(o_steps), 32'd5);
    checkOutput("abortReady", 32'(o_cmd_ready), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("abortDoneCount", 32'(doneCount - d0), 32'd1);

    // Abort on the final advance of STEP 4 from seed 2: 2->4->9->3->6
    applyStimulus(2'd0, 8'd2);
    applyStimulus(2'd1, 8'd4);
    d0 = doneCount;
    repeat (3) begin @(posedge clk); #1; end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    checkOutput("lastAbortDone", 32'(o_done), 32'd1);
    checkOutput("lastAbortState", 32'(o_state), 32'd6);
    checkOutput("lastAbortSteps", 32'(o_steps), 32'd4);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("lastAbortDoneCount", 32'(doneCount - d0), 32'd1);

    // SEED 5 held during STEP 3 is taken only once the FSM is idle again
    applyStimulus(2'd0, 8'd1);
    applyStimulus(2'd1, 8'd3);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'd0;
    i_cmd_arg   = 8'd5;
    @(posedge clk); #1;
    checkOutput("heldReady", 32'(o_cmd_ready), 32'd0);
    checkOutput("heldState1", 32'(o_state), 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("heldStepState", 32'(o_state), 32'd9);
    checkOutput("heldStepDone", 32'(o_done), 32'd1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    checkOutput("heldSeedState", 32'(o_state), 32'd5);
    checkOutput("heldSeedDone", 32'(o_done), 32'd1);

    // Asynchronous reset in the middle of a STEP
    applyStimulus(2'd0, 8'd1);
    applyStimulus(2'd1, 8'd10);
    d0 = doneCount;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("preRstState", 32'(o_state), 32'd9);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstState", 32'(o_state), 32'd1);
    checkOutput("midRstBusy", 32'(o_busy), 32'd0);
    checkOutput("midRstReady", 32'(o_cmd_ready), 32'd1);
    checkOutput("midRstSteps", 32'(o_steps), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("postRstState", 32'(o_state), 32'd1);
    checkOutput("postRstDoneCount", 32'(doneCount - d0), 32'd0);

`ifdef LFSR_SEQ_CTRL_LOCKUP_DET_EN
    // Zero seed rejected
    applyStimulus(2'd0, 8'd0);
    waitDone(4, edges);
    checkOutput("zeroSeedLatency", 32'(edges), 32'd0);
    checkOutput("zeroSeedErr", 32'(o_err), 32'd1);
    checkOutput("zeroSeedState", 32'(o_state), 32'd1);
`else
    // Zero seed locks the LFSR; SEEK 5 times out after 15 edges
    applyStimulus(2'd0, 8'd0);
    checkOutput("zeroSeedState", 32'(o_state), 32'd0);
    applyStimulus(2'd2, 8'd5);
    waitDone(20, edges);
    checkOutput("lockSeekLatency", 32'(edges), 32'd15);
    checkOutput("lockSeekSteps", 32'(o_steps), 32'd15);
    checkOutput("lockSeekMatch", 32'(o_match), 32'd0);
    checkOutput("lockSeekState", 32'(o_state), 32'd0);
    checkOutput("lockSeekErr", 32'(o_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
